iterative_alu: RTL and testbench
================================

// Module: iterative_alu
// PURPOSE
//  Execute-stage ALU that consumes the 4-bit Operation code produced by the ALU controller.
//  Operands are accepted through a valid/ready handshake, and the result is returned through a second one.
//  Logic, arithmetic and compare ops take one cycle.
//  Shifts run iteratively, SHIFT_STEP bits per cycle, which avoids a full barrel shifter.
// PARAMETERS
//  DATA_WIDTH  32  operand/result width; power of two, >= 8
//  SHIFT_STEP  1   bits shifted per SHIFT cycle; power of two, 1..DATA_WIDTH
// PORTS
//  clk        in   1           rising-edge clock
//  rst_n      in   1           asynchronous active-low reset
//  in_valid   in   1           Operation/SrcA/SrcB valid
//  in_ready   out  1           block can accept an op
//  Operation  in   4           op code (see encoding)
//  SrcA       in   DATA_WIDTH  operand A (value shifted for shifts)
//  SrcB       in   DATA_WIDTH  operand B (shift amount for shifts)
//  out_valid  out  1           ALUResult/Zero valid
//  out_ready  in   1           consumer takes the result
//  ALUResult  out  DATA_WIDTH  result
//  Zero       out  1           ALUResult == 0 (combinational from ALUResult)
// BEHAVIOUR
//  Encoding:
//   0000 AND; 0001 OR; 0010 ADD; 0011 XOR; 0100 SLL; 0101 SRL; 0110 SUB; 0111 SRA
//   1000 EQ; 1001 NE; 1010 GE (signed); 1100 LT (signed, also SLT); 1101 JUMP (result = 1)
//   1011/1110/1111: result 0, single-cycle
//  Compares: result = {DATA_WIDTH-1 zeros, flag}.
//  ADD/SUB wrap modulo 2^DATA_WIDTH; no overflow output.
//  Shift amount = SrcB[$clog2(DATA_WIDTH)-1:0]; upper SrcB bits ignored.
//  SRA fills with SrcA MSB; SLL/SRL fill with 0.
//  Inputs are sampled only on the accept edge (in_valid && in_ready); they may change at any other time.
//  FSM states IDLE, SHIFT, DONE:
//   IDLE : in_ready=1, out_valid=0. On accept:
//          non-shift op or shift amount 0 -> register result (amt 0: SrcA), go to DONE;
//          shift op with amt>0 -> latch SrcA, amt and kind, go to SHIFT.
//   SHIFT: in_ready=0, out_valid=0.
//          Each cycle shift by min(SHIFT_STEP, remaining) and decrement remaining.
//          When remaining reaches 0 -> DONE.
//   DONE : out_valid=1, in_ready=0; ALUResult and Zero held stable.
//          out_ready=1 -> IDLE on that edge. out_ready held low -> stay in DONE indefinitely.
//  Latency (accept edge to first cycle with out_valid=1):
//   non-shift ops and shifts by 0: 1 cycle;
//   shifts by amt>0: 1 + ceil(amt/SHIFT_STEP) cycles.
//  No overlap: in_ready is low from accept until the result is taken. Peak throughput is 1 op / 2 cycles.
//  Reset (asynchronous, any state, including mid-SHIFT):
//   state=IDLE, out_valid=0, ALUResult=0 (so Zero=1); the in-flight op is discarded.
//   in_ready=1 from the first clock after rst_n deasserts.
// TESTING (DATA_WIDTH=32)
//  1 ADD 0x7FFFFFFF+0x1 -> 0x80000000, Zero=0, out_valid 1 cycle after accept.
//    SUB 5-5 -> 0, Zero=1.
//  2 SRA SrcA=0x80000000, SrcB=0x24 (masked to 4), STEP=1 -> 0xF8000000, out_valid 5 cycles after accept.
//  3 SLL amt 0 -> SrcA after 1 cycle.
//    SLL 0x1 by 31 with STEP=4 -> 0x80000000 after 9 cycles.
//  4 out_ready low 10 cycles in DONE -> out_valid, ALUResult and Zero stable, in_ready=0;
//    out_ready high -> IDLE next cycle.
//  5 LT(0xFFFFFFFF,1)=1; GE same operands=0; EQ(3,3)=1; NE(3,3)=0; JUMP=1; code 1111 -> 0, Zero=1.
//  6 rst_n low mid-SHIFT -> out_valid=0 and ALUResult=0 immediately (no clock edge needed);
//    after release, no stale result and the next op completes correctly.

Source files
------------

// File: rtl/iterative_alu_if.sv
// rtl/iterative_alu_if.sv - operand/result handshake bundle for iterative_alu
interface iterative_alu_if #(
    parameter int DATA_WIDTH = 32
);
    logic                  in_valid;
    logic                  in_ready;
    logic [3:0]            Operation;
    logic [DATA_WIDTH-1:0] SrcA;
    logic [DATA_WIDTH-1:0] SrcB;
    logic                  out_valid;
    logic                  out_ready;
    logic [DATA_WIDTH-1:0] ALUResult;
    logic                  Zero;

    modport master (
        output in_valid, Operation, SrcA, SrcB, out_ready,
        input  in_ready, out_valid, ALUResult, Zero
    );

    modport slave (
        input  in_valid, Operation, SrcA, SrcB, out_ready,
        output in_ready, out_valid, ALUResult, Zero
    );
endinterface

// File: rtl/iterative_alu.sv
// rtl/iterative_alu.sv - execute-stage ALU with single-cycle logic/arith and iterative shifts
module iterative_alu #(
    parameter int DATA_WIDTH = 32,
    parameter int SHIFT_STEP = 1
) (
    input  logic            clk,
    input  logic            rst_n,
    iterative_alu_if.slave  bus
);
    localparam int AW = $clog2(DATA_WIDTH);

    localparam logic [3:0] OP_AND  = 4'b0000;
    localparam logic [3:0] OP_OR   = 4'b0001;
    localparam logic [3:0] OP_ADD  = 4'b0010;
    localparam logic [3:0] OP_XOR  = 4'b0011;
    localparam logic [3:0] OP_SLL  = 4'b0100;
    localparam logic [3:0] OP_SRL  = 4'b0101;
    localparam logic [3:0] OP_SUB  = 4'b0110;
    localparam logic [3:0] OP_SRA  = 4'b0111;
    localparam logic [3:0] OP_EQ   = 4'b1000;
    localparam logic [3:0] OP_NE   = 4'b1001;
    localparam logic [3:0] OP_GE   = 4'b1010;
    localparam logic [3:0] OP_LT   = 4'b1100;
    localparam logic [3:0] OP_JUMP = 4'b1101;

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

    state_t                state_q, state_d;
    logic [DATA_WIDTH-1:0] result_q, result_d;
    logic [AW-1:0]         rem_q, rem_d;
    logic [1:0]            kind_q, kind_d;

    logic [AW-1:0]         amt;
    logic                  is_shift;
    logic [AW:0]           step;
    logic [DATA_WIDTH-1:0] shifted;

    function automatic logic [DATA_WIDTH-1:0] single_cycle(
        input logic [3:0]            op,
        input logic [DATA_WIDTH-1:0] a,
        input logic [DATA_WIDTH-1:0] b
    );
        logic [DATA_WIDTH-1:0] r;
        r = '0;
        case (op)
            OP_AND:  r = a & b;
            OP_OR:   r = a | b;
            OP_ADD:  r = a + b;
            OP_XOR:  r = a ^ b;
            OP_SUB:  r = a - b;
            OP_EQ:   r = {{(DATA_WIDTH-1){1'b0}}, (a == b)};
            OP_NE:   r = {{(DATA_WIDTH-1){1'b0}}, (a != b)};
            OP_GE:   r = {{(DATA_WIDTH-1){1'b0}}, ($signed(a) >= $signed(b))};
            OP_LT:   r = {{(DATA_WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
            OP_JUMP: r = {{(DATA_WIDTH-1){1'b0}}, 1'b1};
            default: r = '0;
        endcase
        return r;
    endfunction

    assign amt      = bus.SrcB[AW-1:0];
    assign is_shift = (bus.Operation == OP_SLL) || (bus.Operation == OP_SRL) ||
                      (bus.Operation == OP_SRA);

    // Last iteration may need fewer than SHIFT_STEP bits
    assign step = ({1'b0, rem_q} < (AW+1)'(SHIFT_STEP)) ? {1'b0, rem_q} : (AW+1)'(SHIFT_STEP);

    always_comb begin
        shifted = '0;
        case (kind_q)
            2'b00:   shifted = result_q << step;
            2'b01:   shifted = result_q >> step;
            default: shifted = $unsigned($signed(result_q) >>> step);
        endcase
    end

    always_comb begin
        state_d  = state_q;
        result_d = result_q;
        rem_d    = rem_q;
        kind_d   = kind_q;
        case (state_q)
            IDLE: begin
                if (bus.in_valid) begin
                    if (is_shift && amt != '0) begin
                        result_d = bus.SrcA;
                        rem_d    = amt;
                        kind_d   = bus.Operation[1:0];
                        state_d  = SHIFT;
                    end else begin
                        result_d = is_shift ? bus.SrcA
                                            : single_cycle(bus.Operation, bus.SrcA, bus.SrcB);
                        state_d  = DONE;
                    end
                end
            end
            SHIFT: begin
                result_d = shifted;
                rem_d    = rem_q - step[AW-1:0];
                if (rem_d == '0) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                if (bus.out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            result_q <= '0;
            rem_q    <= '0;
            kind_q   <= '0;
        end else begin
            state_q  <= state_d;
            result_q <= result_d;
            rem_q    <= rem_d;
            kind_q   <= kind_d;
        end
    end

    assign bus.in_ready  = (state_q == IDLE);
    assign bus.out_valid = (state_q == DONE);
    assign bus.ALUResult = result_q;
    assign bus.Zero      = (result_q == '0);
endmodule

// File: tb/tb_iterative_alu.sv
// tb/tb_iterative_alu.sv - directed vector bench for iterative_alu at SHIFT_STEP 1 and 4
module tb_iterative_alu;
    localparam logic [3:0] OP_AND  = 4'b0000;
    localparam logic [3:0] OP_OR   = 4'b0001;
    localparam logic [3:0] OP_ADD  = 4'b0010;
    localparam logic [3:0] OP_XOR  = 4'b0011;
    localparam logic [3:0] OP_SLL  = 4'b0100;
    localparam logic [3:0] OP_SRL  = 4'b0101;
    localparam logic [3:0] OP_SUB  = 4'b0110;
    localparam logic [3:0] OP_SRA  = 4'b0111;
    localparam logic [3:0] OP_EQ   = 4'b1000;
    localparam logic [3:0] OP_NE   = 4'b1001;
    localparam logic [3:0] OP_GE   = 4'b1010;
    localparam logic [3:0] OP_LT   = 4'b1100;
    localparam logic [3:0] OP_JUMP = 4'b1101;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        out_ready;
    logic [3:0]  op;
    logic [31:0] src_a;
    logic [31:0] src_b;

    always #5 clk = ~clk;

    iterative_alu_if #(.DATA_WIDTH(32)) bus1 ();
    iterative_alu_if #(.DATA_WIDTH(32)) bus4 ();

    assign bus1.in_valid  = in_valid;
    assign bus1.Operation = op;
    assign bus1.SrcA      = src_a;
    assign bus1.SrcB      = src_b;
    assign bus1.out_ready = out_ready;
    assign bus4.in_valid  = in_valid;
    assign bus4.Operation = op;
    assign bus4.SrcA      = src_a;
    assign bus4.SrcB      = src_b;
    assign bus4.out_ready = out_ready;

    iterative_alu #(.DATA_WIDTH(32), .SHIFT_STEP(1)) dut1 (.clk(clk), .rst_n(rst_n), .bus(bus1));
    iterative_alu #(.DATA_WIDTH(32), .SHIFT_STEP(4)) dut4 (.clk(clk), .rst_n(rst_n), .bus(bus4));

    typedef struct {
        logic [3:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] res;
        int          lat1;
        int          lat4;
    } vec_t;

    vec_t vq[$];
    int   checks   = 0;
    int   failures = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%08h expected=0x%08h", name, act, exp);
        end
    endtask

    task automatic add(input logic [3:0] o, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] r, input int l1, input int l4);
        vec_t v;
        v.op = o; v.a = a; v.b = b; v.res = r; v.lat1 = l1; v.lat4 = l4;
        vq.push_back(v);
    endtask

    task automatic issue(input string name, input logic [3:0] o,
                         input logic [31:0] a, input logic [31:0] b);
        @(negedge clk);
        check({name, " in_ready1"}, 32'(bus1.in_ready), 32'd1);
        check({name, " in_ready4"}, 32'(bus4.in_ready), 32'd1);
        op = o; src_a = a; src_b = b; in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        op    = 4'($urandom);
        src_a = $urandom;
        src_b = $urandom;
    endtask

    task automatic wait_both(output int l1, output int l4);
        l1 = 0;
        l4 = 0;
        for (int k = 1; k <= 100 && (l1 == 0 || l4 == 0); k++) begin
            @(negedge clk);
            if (bus1.out_valid && l1 == 0) l1 = k;
            if (bus4.out_valid && l4 == 0) l4 = k;
        end
    endtask

    task automatic take(input string name);
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        @(negedge clk);
        check({name, " idle out_valid1"}, 32'(bus1.out_valid), 32'd0);
        check({name, " idle out_valid4"}, 32'(bus4.out_valid), 32'd0);
        check({name, " idle in_ready1"}, 32'(bus1.in_ready), 32'd1);
        check({name, " idle in_ready4"}, 32'(bus4.in_ready), 32'd1);
    endtask

    task automatic run_vec(input string name, input vec_t v);
        int l1, l4;
        issue(name, v.op, v.a, v.b);
        wait_both(l1, l4);
        check({name, " res1"}, bus1.ALUResult, v.res);
        check({name, " res4"}, bus4.ALUResult, v.res);
        check({name, " zero1"}, 32'(bus1.Zero), 32'(v.res == 32'd0));
        check({name, " zero4"}, 32'(bus4.Zero), 32'(v.res == 32'd0));
        check({name, " lat1"}, 32'(l1), 32'(v.lat1));
        check({name, " lat4"}, 32'(l4), 32'(v.lat4));
        take(name);
    endtask

    task automatic check_reset_state(input string name);
        check({name, " out_valid1"}, 32'(bus1.out_valid), 32'd0);
        check({name, " out_valid4"}, 32'(bus4.out_valid), 32'd0);
        check({name, " result1"}, bus1.ALUResult, 32'd0);
        check({name, " result4"}, bus4.ALUResult, 32'd0);
        check({name, " zero1"}, 32'(bus1.Zero), 32'd1);
        check({name, " zero4"}, 32'(bus4.Zero), 32'd1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t v;
        int   l1, l4;

        add(OP_ADD,  32'h7FFF_FFFF, 32'h0000_0001, 32'h8000_0000,  1, 1);
        add(OP_SUB,  32'd5,         32'd5,         32'h0000_0000,  1, 1);
        add(OP_SUB,  32'd0,         32'd1,         32'hFFFF_FFFF,  1, 1);
        add(OP_AND,  32'hF0F0_1234, 32'h0FF0_FFFF, 32'h00F0_1234,  1, 1);
        add(OP_OR,   32'hF000_0000, 32'h0000_000F, 32'hF000_000F,  1, 1);
        add(OP_XOR,  32'hA5A5_A5A5, 32'hFFFF_0000, 32'h5A5A_A5A5,  1, 1);
        add(OP_SRA,  32'h8000_0000, 32'h0000_0024, 32'hF800_0000,  5, 2);
        add(OP_SLL,  32'h0000_1234, 32'h0000_0020, 32'h0000_1234,  1, 1);
        add(OP_SLL,  32'h0000_0001, 32'd31,        32'h8000_0000, 32, 9);
        add(OP_SRL,  32'h8000_0000, 32'd31,        32'h0000_0001, 32, 9);
        add(OP_SRA,  32'h7000_0000, 32'd5,         32'h0380_0000,  6, 3);
        add(OP_SRL,  32'hF000_0000, 32'd6,         32'h03C0_0000,  7, 3);
        add(OP_SRA,  32'h8000_0000, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32, 9);
        add(OP_SLL,  32'h0000_00FF, 32'd8,         32'h0000_FF00,  9, 3);
        add(OP_LT,   32'hFFFF_FFFF, 32'd1,         32'd1,          1, 1);
        add(OP_GE,   32'hFFFF_FFFF, 32'd1,         32'd0,          1, 1);
        add(OP_LT,   32'd1,         32'hFFFF_FFFF, 32'd0,          1, 1);
        add(OP_GE,   32'd5,         32'd5,         32'd1,          1, 1);
        add(OP_EQ,   32'd3,         32'd3,         32'd1,          1, 1);
        add(OP_NE,   32'd3,         32'd3,         32'd0,          1, 1);
        add(OP_JUMP, 32'h1234_5678, 32'h9ABC_DEF0, 32'd1,          1, 1);
        add(4'b1111, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd0,          1, 1);
        add(4'b1011, 32'd7,         32'd9,         32'd0,          1, 1);
        add(4'b1110, 32'hDEAD_BEEF, 32'h1,         32'd0,          1, 1);

        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        op = 4'd0; src_a = 32'd0; src_b = 32'd0;
        repeat (3) @(negedge clk);
        check_reset_state("por");
        rst_n = 1'b1;
        @(negedge clk);
        check("por in_ready1", 32'(bus1.in_ready), 32'd1);
        check("por in_ready4", 32'(bus4.in_ready), 32'd1);

        for (int i = 0; i < vq.size(); i++) begin
            v = vq[i];
            run_vec($sformatf("v%0d", i), v);
        end

        // Result held while the consumer stalls
        issue("hold", OP_SUB, 32'd7, 32'd7);
        wait_both(l1, l4);
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            check($sformatf("hold%0d out_valid1", k), 32'(bus1.out_valid), 32'd1);
            check($sformatf("hold%0d out_valid4", k), 32'(bus4.out_valid), 32'd1);
            check($sformatf("hold%0d res1", k), bus1.ALUResult, 32'd0);
            check($sformatf("hold%0d zero1", k), 32'(bus1.Zero), 32'd1);
            check($sformatf("hold%0d res4", k), bus4.ALUResult, 32'd0);
            check($sformatf("hold%0d in_ready1", k), 32'(bus1.in_ready), 32'd0);
            check($sformatf("hold%0d in_ready4", k), 32'(bus4.in_ready), 32'd0);
        end
        take("hold");

        // Asynchronous reset in the middle of a shift
        issue("rs", OP_SLL, 32'h0000_0001, 32'd20);
        repeat (3) @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check_reset_state("rst_shift");
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("rst_shift in_ready1", 32'(bus1.in_ready), 32'd1);
        check("rst_shift in_ready4", 32'(bus4.in_ready), 32'd1);
        repeat (25) @(negedge clk);
        check("rst_shift stale1", 32'(bus1.out_valid), 32'd0);
        check("rst_shift stale4", 32'(bus4.out_valid), 32'd0);
        v.op = OP_SRL; v.a = 32'h0000_0100; v.b = 32'd3; v.res = 32'h0000_0020;
        v.lat1 = 4; v.lat4 = 2;
        run_vec("post_rst", v);

        // Asynchronous reset while a result is waiting
        issue("rd", OP_JUMP, 32'd0, 32'd0);
        wait_both(l1, l4);
        #2;
        rst_n = 1'b0;
        #1;
        check_reset_state("rst_done");
        @(negedge clk);
        rst_n = 1'b1;
        v.op = OP_ADD; v.a = 32'd40; v.b = 32'd2; v.res = 32'd42; v.lat1 = 1; v.lat4 = 1;
        run_vec("post_rst2", v);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
